// File: rtl/plic_ctrl.sv
// Platform-level interrupt controller: per-source gateways, priority arbitration
// against a threshold, and a claim/complete handshake on a byte-wide bus.
module plic_ctrl #(
   parameter int                 NUM_SRC   = 4,
   parameter int                 PRIO_W    = 3,
   parameter logic [NUM_SRC-1:0] EDGE_MASK = '0
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [7:0]         i_data,
   input  logic [23:0]        i_address,
   input  logic               i_write,
   input  logic               i_request,
   output logic [7:0]         o_data,
   output logic               o_data_DV,
   input  logic [NUM_SRC-1:0] i_irq,
   output logic               o_interrupt
);

   localparam logic [23:0] ADDR_THRESH = 24'h201000;
   localparam logic [23:0] ADDR_CLAIM  = 24'h201004;
   localparam logic [21:0] WORD_PEND   = 22'h000400;
   localparam logic [21:0] WORD_EN     = 22'h000820;

   logic [PRIO_W-1:0]  r_prio [NUM_SRC];
   logic [PRIO_W-1:0]  r_threshold;
   logic [NUM_SRC-1:0] r_enable;
   logic [NUM_SRC-1:0] r_pending;
   logic [NUM_SRC-1:0] r_in_service;
   logic [NUM_SRC-1:0] r_irq_prev;
   logic [7:0]         r_data;
   logic               r_data_dv;
   logic               r_interrupt;

   logic               w_rd;
   logic               w_wr;
   logic               w_prio_sel;
   logic [9:0]         w_prio_id;
   logic               w_pend_sel;
   logic               w_en_sel;
   logic [1:0]         w_byte;
   logic               w_thr_sel;
   logic               w_claim_sel;
   logic [31:0]        w_pend32;
   logic [31:0]        w_en32;
   logic [7:0]         w_prio_rd;
   logic [7:0]         w_rdata;
   logic [NUM_SRC-1:0] w_eligible;
   logic [NUM_SRC-1:0] w_take;
   logic               w_win_valid;
   logic [PRIO_W-1:0]  w_win_prio;
   logic [7:0]         w_win_id;
   logic               w_claim_fire;
   logic               w_cmpl;
   logic [NUM_SRC-1:0] w_evt;
   logic [NUM_SRC-1:0] w_pend_nxt;
   logic [NUM_SRC-1:0] w_isv_nxt;

   assign o_data      = r_data;
   assign o_data_DV   = r_data_dv;
   assign o_interrupt = r_interrupt;

   assign w_rd        = i_request & ~i_write;
   assign w_wr        = i_request & i_write;
   assign w_prio_sel  = (i_address[23:12] == 12'h000) && (i_address[1:0] == 2'b00);
   assign w_prio_id   = i_address[11:2];
   assign w_pend_sel  = (i_address[23:2] == WORD_PEND);
   assign w_en_sel    = (i_address[23:2] == WORD_EN);
   assign w_byte      = i_address[1:0];
   assign w_thr_sel   = (i_address == ADDR_THRESH);
   assign w_claim_sel = (i_address == ADDR_CLAIM);

   // Flatten per-source state into the 32-bit ID-indexed view the bus exposes.
   always_comb begin
      w_pend32   = 32'd0;
      w_en32     = 32'd0;
      w_prio_rd  = 8'h00;
      w_eligible = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         w_pend32[k+1] = r_pending[k];
         w_en32[k+1]   = r_enable[k];
         w_prio_rd     = (w_prio_id == 10'(k + 1)) ? 8'(r_prio[k]) : w_prio_rd;
         w_eligible[k] = r_pending[k] & r_enable[k] & (r_prio[k] != '0);
      end
   end

   // Highest priority wins; strict compare in ascending order keeps the lowest ID on ties.
   always_comb begin
      w_take      = '0;
      w_win_valid = 1'b0;
      w_win_prio  = '0;
      w_win_id    = 8'h00;
      for (int k = 0; k < NUM_SRC; k++) begin
         w_take[k]   = w_eligible[k] & (~w_win_valid | (r_prio[k] > w_win_prio));
         w_win_valid = w_win_valid | w_take[k];
         w_win_prio  = w_take[k] ? r_prio[k] : w_win_prio;
         w_win_id    = w_take[k] ? 8'(k + 1) : w_win_id;
      end
   end

   // Read-data mux for the addressed register.
   always_comb begin
      w_rdata = 8'h00;
      if (w_prio_sel) begin
         w_rdata = w_prio_rd;
      end else if (w_pend_sel || w_en_sel) begin
         case (w_byte)
            2'd0:    w_rdata = w_pend_sel ? w_pend32[7:0]   : w_en32[7:0];
            2'd1:    w_rdata = w_pend_sel ? w_pend32[15:8]  : w_en32[15:8];
            2'd2:    w_rdata = w_pend_sel ? w_pend32[23:16] : w_en32[23:16];
            2'd3:    w_rdata = w_pend_sel ? w_pend32[31:24] : w_en32[31:24];
            default: w_rdata = 8'h00;
         endcase
      end else if (w_thr_sel) begin
         w_rdata = 8'(r_threshold);
      end else if (w_claim_sel) begin
         w_rdata = w_win_id;
      end else begin
         w_rdata = 8'h00;
      end
   end

   assign w_claim_fire = w_rd & w_claim_sel & w_win_valid;
   assign w_cmpl       = w_wr & w_claim_sel;

   // Gateways and claim/complete: a claim overrides a same-cycle gateway set.
   always_comb begin
      w_evt      = '0;
      w_pend_nxt = '0;
      w_isv_nxt  = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         w_evt[k] = EDGE_MASK[k] ? (i_irq[k] & ~r_irq_prev[k]) : i_irq[k];
         if (w_claim_fire && (w_win_id == 8'(k + 1))) begin
            w_pend_nxt[k] = 1'b0;
            w_isv_nxt[k]  = 1'b1;
         end else if (w_cmpl && (i_data == 8'(k + 1)) && r_in_service[k]) begin
            w_pend_nxt[k] = r_pending[k] | (w_evt[k] & ~r_in_service[k]);
            w_isv_nxt[k]  = 1'b0;
         end else begin
            w_pend_nxt[k] = r_pending[k] | (w_evt[k] & ~r_in_service[k]);
            w_isv_nxt[k]  = r_in_service[k];
         end
      end
   end

   // Register file, bus response and interrupt output.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            r_prio[k] <= '0;
         end
         r_threshold  <= '0;
         r_enable     <= '0;
         r_pending    <= '0;
         r_in_service <= '0;
         r_irq_prev   <= '0;
         r_data       <= 8'h00;
         r_data_dv    <= 1'b0;
         r_interrupt  <= 1'b0;
      end else begin
         r_data_dv    <= i_request;
         r_interrupt  <= w_win_valid && (w_win_prio > r_threshold);
         r_irq_prev   <= i_irq;
         r_pending    <= w_pend_nxt;
         r_in_service <= w_isv_nxt;
         if (w_rd) begin
            r_data <= w_rdata;
         end
         if (w_wr && w_thr_sel) begin
            r_threshold <= i_data[PRIO_W-1:0];
         end
         for (int k = 0; k < NUM_SRC; k++) begin
            if (w_wr && w_prio_sel && (w_prio_id == 10'(k + 1))) begin
               r_prio[k] <= i_data[PRIO_W-1:0];
            end
            if (w_wr && w_en_sel && (w_byte == 2'((k + 1) >> 3))) begin
               r_enable[k] <= i_data[(k + 1) % 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_plic_ctrl.sv
// Directed bench for plic_ctrl: one level-triggered and one edge-triggered
// instance share the bus; register vectors come from a table.
module tb_plic_ctrl;

   localparam logic [23:0] A_PEND  = 24'h001000;
   localparam logic [23:0] A_EN    = 24'h002080;
   localparam logic [23:0] A_THR   = 24'h201000;
   localparam logic [23:0] A_CLAIM = 24'h201004;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        wr;
   logic [23:0] addr;
   logic [7:0]  wdata;
   logic [3:0]  irq_lvl;
   logic [3:0]  irq_edge;
   logic [7:0]  rd_lvl;
   logic [7:0]  rd_edge;
   logic        dv_lvl;
   logic        dv_edge;
   logic        int_lvl;
   logic        int_edge;
   int          checks   = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   plic_ctrl #(.NUM_SRC(4), .PRIO_W(3), .EDGE_MASK(4'b0000)) u_lvl (
      .i_clk(clk), .i_reset(rst), .i_data(wdata), .i_address(addr),
      .i_write(wr), .i_request(req), .o_data(rd_lvl), .o_data_DV(dv_lvl),
      .i_irq(irq_lvl), .o_interrupt(int_lvl)
   );

   plic_ctrl #(.NUM_SRC(4), .PRIO_W(3), .EDGE_MASK(4'b0001)) u_edge (
      .i_clk(clk), .i_reset(rst), .i_data(wdata), .i_address(addr),
      .i_write(wr), .i_request(req), .o_data(rd_edge), .o_data_DV(dv_edge),
      .i_irq(irq_edge), .o_interrupt(int_edge)
   );

   typedef struct {
      logic        wr;
      logic [23:0] addr;
      logic [7:0]  data;
      logic [7:0]  exp;
   } vec_t;

   vec_t vecs [23];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%02h expected=0x%02h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One bus access; returns at the negedge of the response cycle.
   task automatic acc(input logic w, input logic [23:0] a, input logic [7:0] d);
      wr = w; addr = a; wdata = d; req = 1'b1;
      @(negedge clk);
      req = 1'b0; wr = 1'b0;
      chk("dv_pulse", {6'd0, dv_lvl, dv_edge}, 8'h03);
   endtask

   task automatic wreg(input logic [23:0] a, input logic [7:0] d);
      acc(1'b1, a, d);
   endtask

   task automatic rlvl(input string name, input logic [23:0] a, input logic [7:0] exp);
      acc(1'b0, a, 8'h00);
      chk(name, rd_lvl, exp);
   endtask

   task automatic redge(input string name, input logic [23:0] a, input logic [7:0] exp);
      acc(1'b0, a, 8'h00);
      chk(name, rd_edge, exp);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; wr = 1'b0; addr = 24'h0; wdata = 8'h00;
      irq_lvl = 4'h0; irq_edge = 4'h0;

      vecs[0]  = '{1'b1, 24'h000004, 8'hFA, 8'h00};
      vecs[1]  = '{1'b0, 24'h000004, 8'h00, 8'h02};
      vecs[2]  = '{1'b1, 24'h000008, 8'h05, 8'h00};
      vecs[3]  = '{1'b0, 24'h000008, 8'h00, 8'h05};
      vecs[4]  = '{1'b1, 24'h000000, 8'h07, 8'h00};
      vecs[5]  = '{1'b0, 24'h000000, 8'h00, 8'h00};
      vecs[6]  = '{1'b1, 24'h000014, 8'h07, 8'h00};
      vecs[7]  = '{1'b0, 24'h000014, 8'h00, 8'h00};
      vecs[8]  = '{1'b1, 24'h000005, 8'h07, 8'h00};
      vecs[9]  = '{1'b0, 24'h000004, 8'h00, 8'h02};
      vecs[10] = '{1'b1, 24'h002080, 8'hFF, 8'h00};
      vecs[11] = '{1'b0, 24'h002080, 8'h00, 8'h1E};
      vecs[12] = '{1'b1, 24'h002081, 8'hFF, 8'h00};
      vecs[13] = '{1'b0, 24'h002081, 8'h00, 8'h00};
      vecs[14] = '{1'b1, 24'h002080, 8'h06, 8'h00};
      vecs[15] = '{1'b0, 24'h002080, 8'h00, 8'h06};
      vecs[16] = '{1'b1, 24'h201000, 8'h0F, 8'h00};
      vecs[17] = '{1'b0, 24'h201000, 8'h00, 8'h07};
      vecs[18] = '{1'b1, 24'h201000, 8'h00, 8'h00};
      vecs[19] = '{1'b0, 24'h201000, 8'h00, 8'h00};
      vecs[20] = '{1'b0, 24'h001000, 8'h00, 8'h00};
      vecs[21] = '{1'b0, 24'h201005, 8'h00, 8'h00};
      vecs[22] = '{1'b0, 24'h123456, 8'h00, 8'h00};

      // Reset state
      cyc(3);
      chk("rst_data", rd_lvl, 8'h00);
      chk("rst_dv", {7'd0, dv_lvl}, 8'h00);
      chk("rst_int", {6'd0, int_lvl, int_edge}, 8'h00);
      rst = 1'b0;
      rlvl("claim_empty", A_CLAIM, 8'h00);
      chk("claim_empty_edge", rd_edge, 8'h00);
      cyc(1);
      chk("dv_single", {6'd0, dv_lvl, dv_edge}, 8'h00);
      chk("int_idle", {6'd0, int_lvl, int_edge}, 8'h00);

      // Register map vectors, applied back to back
      for (int i = 0; i < 23; i++) begin
         acc(vecs[i].wr, vecs[i].addr, vecs[i].data);
         if (!vecs[i].wr) begin
            chk($sformatf("vec%0d_lvl", i), rd_lvl, vecs[i].exp);
            chk($sformatf("vec%0d_edge", i), rd_edge, vecs[i].exp);
         end
      end

      // Two level sources, claim order by priority
      irq_lvl = 4'b0011;
      cyc(1);
      chk("int_lag", {7'd0, int_lvl}, 8'h00);
      cyc(1);
      chk("int_set", {7'd0, int_lvl}, 8'h01);
      rlvl("pend_12", A_PEND, 8'h06);
      rlvl("claim_2", A_CLAIM, 8'h02);
      rlvl("claim_1", A_CLAIM, 8'h01);
      rlvl("claim_0", A_CLAIM, 8'h00);
      chk("int_after_claims", {7'd0, int_lvl}, 8'h00);
      rlvl("pend_insvc", A_PEND, 8'h00);

      // Threshold masks the output but not the claim
      irq_lvl = 4'b0010;
      wreg(A_THR, 8'h05);
      wreg(A_CLAIM, 8'h02);
      cyc(3);
      chk("thr5_block", {7'd0, int_lvl}, 8'h00);
      rlvl("pend_2", A_PEND, 8'h04);
      rlvl("claim_thr", A_CLAIM, 8'h02);
      wreg(A_CLAIM, 8'h02);
      cyc(2);
      wreg(A_THR, 8'h04);
      chk("thr4_lag", {7'd0, int_lvl}, 8'h00);
      cyc(1);
      chk("thr4_int", {7'd0, int_lvl}, 8'h01);

      // Level ID 1 held high through service, re-pends one cycle after completion
      irq_lvl = 4'b0011;
      wreg(A_THR, 8'h00);
      rlvl("claim_2b", A_CLAIM, 8'h02);
      cyc(1);
      chk("int_drop", {7'd0, int_lvl}, 8'h00);
      rlvl("pend_held", A_PEND, 8'h00);
      wreg(A_CLAIM, 8'h01);
      rlvl("pend_lag", A_PEND, 8'h00);
      rlvl("pend_reset", A_PEND, 8'h02);
      chk("int_reassert", {7'd0, int_lvl}, 8'h01);

      // Reset during an access discards it
      irq_lvl = 4'h0;
      rst = 1'b1; addr = A_CLAIM; wr = 1'b0; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      chk("rst_discard", {6'd0, dv_lvl, dv_edge}, 8'h00);
      cyc(1);
      rst = 1'b0;

      // Equal priorities: lowest ID first; bogus completions ignored
      wreg(24'h000004, 8'h03);
      wreg(24'h00000C, 8'h03);
      wreg(A_EN, 8'h0A);
      irq_lvl = 4'b0101;
      cyc(2);
      chk("eq_int", {7'd0, int_lvl}, 8'h01);
      rlvl("eq_claim_1", A_CLAIM, 8'h01);
      rlvl("eq_claim_3", A_CLAIM, 8'h03);
      wreg(A_CLAIM, 8'h81);
      wreg(A_CLAIM, 8'h04);
      wreg(A_CLAIM, 8'h21);
      cyc(2);
      rlvl("ignored_cmpl", A_CLAIM, 8'h00);
      chk("eq_int_off", {7'd0, int_lvl}, 8'h00);

      // Edge-triggered ID 1
      irq_lvl = 4'h0;
      do_reset();
      wreg(24'h000004, 8'h01);
      wreg(A_EN, 8'h02);
      irq_edge = 4'b0001;
      cyc(1);
      irq_edge = 4'b0000;
      cyc(1);
      chk("edge_int", {7'd0, int_edge}, 8'h01);
      redge("edge_pend", A_PEND, 8'h02);
      redge("edge_claim", A_CLAIM, 8'h01);
      for (int p = 0; p < 2; p++) begin
         irq_edge = 4'b0001;
         cyc(1);
         irq_edge = 4'b0000;
         cyc(2);
      end
      redge("edge_dropped", A_PEND, 8'h00);
      chk("edge_int_off", {7'd0, int_edge}, 8'h00);
      wreg(A_CLAIM, 8'h01);
      cyc(2);
      redge("edge_no_replay", A_PEND, 8'h00);
      irq_edge = 4'b0001;
      cyc(1);
      redge("edge_new", A_CLAIM, 8'h01);
      wreg(A_CLAIM, 8'h01);
      cyc(3);
      redge("edge_held", A_PEND, 8'h00);
      irq_edge = 4'b0000;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/plic_ctrl.md
# plic_ctrl

Parametrised platform-level interrupt controller on the byte-wide peripheral bus. It gathers NUM_SRC interrupt lines through per-source level/edge gateways and keeps per-source priority, enable, pending and in-service state. It arbitrates the highest-priority eligible source against a threshold and drives a single hart interrupt line. Software acknowledges through a claim/complete register pair.

## Interface
- NUM_SRC, 4, number of sources (1..31); source k drives interrupt ID k+1, and ID 0 means "none"
- PRIO_W, 3, priority/threshold width in bits (1..8)
- EDGE_MASK, 0, NUM_SRC-bit mask: bit k=1 makes source k rising-edge triggered, 0 makes it level-triggered

Ports:
- i_clk  in  1  sole clock; all state updates on its rising edge
- i_reset  in  1  reset, synchronous, active-high
- i_data  in  8  write data byte
- i_address  in  24  byte address
- i_write  in  1  1 = write, 0 = read; qualified by i_request
- i_request  in  1  single-cycle access strobe
- o_data  out  8  registered read data
- o_data_DV  out  1  one-cycle access-done pulse
- i_irq  in  NUM_SRC  raw interrupt lines; bit k maps to ID k+1
- o_interrupt  out  1  registered interrupt request to the hart

## Operation
Register map (byte addresses; unlisted addresses read 0, writes ignored):
- 0x000000+4*id, byte 0: priority[id], R/W, low PRIO_W bits. ID 0 and IDs > NUM_SRC read 0.
- 0x001000..0x001003: pending bits, read-only. Bit n of byte b is pending[8b+n]; bit 0 of byte 0 always reads 0.
- 0x002080..0x002083: enable bits, R/W, same bit layout. Bit 0 and bits for IDs > NUM_SRC read 0 and are not writable.
- 0x201000: threshold, R/W, low PRIO_W bits.
- 0x201004: claim/complete.
  - Read = claim. Returns the current winner ID (0 if none), clears that ID's pending bit and sets its in-service bit.
  - Write = complete. Clears in-service for ID i_data. The write is ignored if that ID is not in service or is out of range.
- 0x201005..0x201007: read 0; no side effects.

Gateway, per source:
- Level sources: pending is set in any cycle the line is high and the source is neither pending nor in service.
- Edge sources: pending is set on a registered 0->1 transition of the line. An edge that arrives while the source is pending or in service is dropped.

Arbitration (combinational):
- Eligible = pending & enabled & priority > 0.
- Winner = the eligible source with the highest priority. Ties go to the lowest ID.
- o_interrupt <= (winner exists) and (priority[winner] > threshold).

Claim behaviour:
- A claim uses the winner in the cycle of the request. It ignores the threshold.
- A claim that returns 0 changes no state.

Simultaneous events:
- Claim and gateway set for the same source in the same cycle: the claim wins. Pending ends up 0 and in-service ends up 1, so the new event is dropped.
- Completion and a high level for the same source in the same cycle: in-service clears at that edge. Pending re-sets one cycle later if the line is still high.

Reset: all priority, enable, threshold, pending and in-service bits clear to 0. The edge detector's previous-value registers also clear to 0. o_data=0, o_data_DV=0, o_interrupt=0. A reset asserted mid-access discards the access, and no DV pulse follows.

## Timing
- Access presented on i_request in cycle N:
  - o_data_DV is high for exactly one cycle in N+1, for reads and writes.
  - For reads, o_data is valid in N+1 and holds until the next read.
  - Register side effects (write, claim) are visible from N+1.
- Back-to-back requests in consecutive cycles are supported, one per cycle.
- Interrupt path: an i_irq event sampled at edge N sets pending at edge N. o_interrupt reflects it after edge N+1.
- Interrupt drop: a claim or complete at edge N is reflected in o_interrupt after edge N+1.
- Priority, enable or threshold writes affect o_interrupt with the same one-cycle lag.

## Test plan
- Reset, then read 0x201004. Expect o_data=0, o_data_DV pulse at N+1, and o_interrupt=0 throughout.
- Setup: priority[1]=2, priority[2]=5, enable=0x06, threshold=0. Raise i_irq[0] and i_irq[1] (level).
  - o_interrupt goes to 1.
  - Claim returns 2, then claim returns 1, then claim returns 0.
  - After both claims, o_interrupt=0.
- Setup: threshold=5 with the above priorities, i_irq[1] high.
  - Expect o_interrupt=0.
  - A claim still returns 2.
  - Write threshold=4: o_interrupt=1 two cycles after the write request.
- Level source held high through the claim of ID 1:
  - Pending stays 0 while in service.
  - Write 1 to 0x201004: pending reads 0x02 at 0x001000 again, and o_interrupt re-asserts.
- Edge source (EDGE_MASK=1), ID 1:
  - Pulse i_irq[0] twice while ID 1 is in service: no new pending.
  - After completion, a single new pulse makes the next claim return 1.
- Equal priorities 3 on IDs 1 and 3, both pending: claim returns 1 first. Completing ID 4 (not in service) is ignored.
